// File: rtl/arbiter_n_to_1_request_memory.sv
// Round-robin merge of N memory request streams into one FWFT FIFO, stamping each
// granted packet with a one-hot source id so its response can be routed back.
module arbiter_n_to_1_request_memory #(
    parameter int ID_LEVEL             = 1,
    parameter int NUM_MEMORY_REQUESTOR = 2,
    parameter int FIFO_ARBITER_DEPTH   = 8,
    parameter int FIFO_WRITE_DEPTH     = 2**$clog2(FIFO_ARBITER_DEPTH+9),
    parameter int PROG_THRESH          = (FIFO_WRITE_DEPTH/2)+3,
    localparam int ID_W                = 16,
    localparam int ADDR_W              = 32,
    localparam int DATA_W              = 32,
    localparam int PAYLOAD_W           = DATA_W + ADDR_W + 5*ID_W
) (
    input  logic                                      ap_clk,
    input  logic                                      ap_rst_n,
    input  logic [NUM_MEMORY_REQUESTOR-1:0]           request_in_valid,
    input  logic [NUM_MEMORY_REQUESTOR*PAYLOAD_W-1:0] request_in_payload,
    output logic [NUM_MEMORY_REQUESTOR-1:0]           arbiter_grant_out,
    input  logic                                      fifo_request_signals_in_rd_en,
    output logic                                      fifo_request_signals_out_full,
    output logic                                      fifo_request_signals_out_empty,
    output logic                                      fifo_request_signals_out_valid,
    output logic                                      fifo_request_signals_out_prog_full,
    output logic                                      request_out_valid,
    output logic [PAYLOAD_W-1:0]                      request_out_payload,
    output logic                                      fifo_setup_signal
);

    localparam int N     = NUM_MEMORY_REQUESTOR;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int AW    = (FIFO_WRITE_DEPTH > 1) ? $clog2(FIFO_WRITE_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_WRITE_DEPTH + 1);

    // Payload layout (LSB first): id_cu, id_bundle, id_lane, id_engine, id_module, address, data.
    function automatic logic [PAYLOAD_W-1:0] stamp_source(input logic [PAYLOAD_W-1:0] pkt,
                                                          input logic [PTR_W-1:0]     k);
        logic [PAYLOAD_W-1:0] res;
        logic [ID_W-1:0]      onehot;
        res       = pkt;
        onehot    = '0;
        onehot[k] = 1'b1;
        if (ID_LEVEL < 5)
            res[ID_LEVEL*ID_W +: ID_W] = onehot;
        return res;
    endfunction

    logic                 fifo_rst;
    logic                 stall;
    logic                 prog_full_reg;
    logic [PTR_W-1:0]     rr_ptr;
    logic [N-1:0]         grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_any;
    logic                 req_vld_p1;
    logic [PAYLOAD_W-1:0] req_payload_p1;
    logic [PAYLOAD_W-1:0] mem [FIFO_WRITE_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_prog_full;
    logic                 wr_en;
    logic                 rd_en;

    // The FIFO reset is a registered copy of the external reset; setup stays high one
    // cycle longer so no grant lands while the FIFO is still clearing.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            fifo_rst          <= 1'b1;
            fifo_setup_signal <= 1'b1;
        end else begin
            fifo_rst          <= 1'b0;
            fifo_setup_signal <= fifo_rst;
        end
    end

    assign prog_full_reg = fifo_request_signals_out_prog_full;
    assign stall         = fifo_setup_signal | prog_full_reg;

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (!stall) begin
            for (int i = 0; i < N; i++) begin
                idx = (int'(rr_ptr) + i) % N;
                if (!grant_any && request_in_valid[idx]) begin
                    grant_any  = 1'b1;
                    grant_idx  = PTR_W'(idx);
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    assign arbiter_grant_out = grant;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            rr_ptr <= '0;
        else if (fifo_rst)
            rr_ptr <= '0;
        else if (grant_any)
            rr_ptr <= (grant_idx == PTR_W'(N-1)) ? '0 : grant_idx + 1'b1;
    end

    // p1: stamped request register, writes the FIFO one cycle after the grant
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            req_vld_p1 <= 1'b0;
        else if (fifo_rst)
            req_vld_p1 <= 1'b0;
        else
            req_vld_p1 <= grant_any;
    end

    always_ff @(posedge ap_clk) begin
        if (grant_any)
            req_payload_p1 <= stamp_source(request_in_payload[grant_idx*PAYLOAD_W +: PAYLOAD_W],
                                           grant_idx);
    end

    assign fifo_empty     = (count == '0);
    assign fifo_full      = (count == CNT_W'(FIFO_WRITE_DEPTH));
    assign fifo_prog_full = (count >= CNT_W'(PROG_THRESH));
    assign wr_en          = req_vld_p1 & ~fifo_full;
    assign rd_en          = fifo_request_signals_in_rd_en & ~fifo_empty;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (fifo_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= (wr_ptr == AW'(FIFO_WRITE_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= (rd_ptr == AW'(FIFO_WRITE_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (wr_en)
            mem[wr_ptr] <= req_payload_p1;
    end

    // p2: registered pop result and FIFO status
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            request_out_valid                  <= 1'b0;
            fifo_request_signals_out_full      <= 1'b0;
            fifo_request_signals_out_empty     <= 1'b1;
            fifo_request_signals_out_valid     <= 1'b0;
            fifo_request_signals_out_prog_full <= 1'b0;
        end else if (fifo_rst) begin
            request_out_valid                  <= 1'b0;
            fifo_request_signals_out_full      <= 1'b0;
            fifo_request_signals_out_empty     <= 1'b1;
            fifo_request_signals_out_valid     <= 1'b0;
            fifo_request_signals_out_prog_full <= 1'b0;
        end else begin
            request_out_valid                  <= rd_en & ~fifo_empty;
            fifo_request_signals_out_full      <= fifo_full;
            fifo_request_signals_out_empty     <= fifo_empty;
            fifo_request_signals_out_valid     <= ~fifo_empty;
            fifo_request_signals_out_prog_full <= fifo_prog_full;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (rd_en)
            request_out_payload <= mem[rd_ptr];
    end

endmodule

// File: doc/arbiter_n_to_1_request_memory.md
# arbiter_N_to_1_request_memory

Merges the memory request streams of `NUM_MEMORY_REQUESTOR` engines into one request stream toward the memory/cache channel. It is the request-side partner of the 1-to-N response demux. It stamps each granted request with a one-hot source id at level `ID_LEVEL`, so the returning response can be routed back to the same requestor. Arbitration is round-robin, and the merged stream is buffered in an FWFT FIFO that the downstream stage pops.

## Interface
Parameters:
- `ID_LEVEL`, default 1: routing level stamped. 0=`id_cu`, 1=`id_bundle`, 2=`id_lane`, 3=`id_engine`, 4=`id_module`, 5=no stamping (field passed unchanged).
- `NUM_MEMORY_REQUESTOR`, default 2: number of request inputs. Legal range is 1–16.
- `FIFO_ARBITER_DEPTH`, default 8: nominal buffering.
- `FIFO_WRITE_DEPTH`, default `2**$clog2(FIFO_ARBITER_DEPTH+9)`: output FIFO depth.
- `PROG_THRESH`, default `(FIFO_WRITE_DEPTH/2)+3`: prog_full threshold. Must satisfy `FIFO_WRITE_DEPTH-PROG_THRESH >= 3`.

Ports (clock and reset first):
- `ap_clk`, in, 1: clock.
- `ap_rst_n`, in, 1: asynchronous, active-low reset.
- `request_in[NUM_MEMORY_REQUESTOR-1:0]`, in, `MemoryPacket`: head of each requestor's FWFT FIFO. `.valid` is level-held while a packet is present.
- `arbiter_grant_out[NUM_MEMORY_REQUESTOR-1:0]`, out, `NUM_MEMORY_REQUESTOR`: per-requestor pop strobe, used as that requestor's FIFO `rd_en`.
- `fifo_request_signals_in`, in, `FIFOStateSignalsInput`: downstream `rd_en`.
- `fifo_request_signals_out`, out, `FIFOStateSignalsOutput`: registered output-FIFO state (full, empty, valid, prog_full).
- `request_out`, out, `MemoryPacket`: merged request.
- `fifo_setup_signal`, out, 1: high while the output FIFO is in reset.

## Operation
- **Reset state.** Reset is asynchronous on all control flops; the FIFO reset is derived from a registered copy of `~ap_rst_n`. Reset values:
  - `arbiter_grant_out` = 0, `request_out.valid` = 0.
  - `fifo_setup_signal` = 1.
  - `fifo_request_signals_out`: full=0, empty=1, valid=0, prog_full=0.
  - Round-robin pointer `rr_ptr` = 0.
- **Stall.** `stall = fifo_setup_signal | prog_full_reg`, where `prog_full_reg` is the registered FIFO prog_full. No grant is issued while `stall`=1.
- **Grant.** `arbiter_grant_out` is combinational from registered state and `request_in[*].valid`:
  - Search order is `rr_ptr, rr_ptr+1, …`, wrapping modulo N. The first valid requestor is granted.
  - At most one grant bit is high per cycle; the output is all-zero when stalled or when no input is valid.
  - The granted packet is consumed in the same cycle.
- **Pointer update.** After a grant to index k, `rr_ptr` becomes `(k+1) mod N`; `rr_ptr` is unchanged on cycles with no grant.
- **Stamp.** The granted payload is captured into a pipeline register, with `packet_source.id_<ID_LEVEL>` overwritten by the one-hot value `1<<k` (upper bits zero). All other fields are unchanged. With `ID_LEVEL`=5 the payload is unmodified.
- **FIFO write.** The pipeline register writes the output FIFO on the cycle after the grant.
- **Pop.** FIFO `rd_en = fifo_request_signals_in.rd_en & ~empty`. `request_out` is registered: `.valid` equals the pop qualified by FIFO valid, and `.payload` equals FIFO dout, one cycle after the pop.
- **Boundary conditions.**
  - Full is unreachable by construction: prog_full stalls grants with at least 3 free entries, which cover the grant→write→prog_full_reg lag.
  - Empty: `rd_en` is gated, and no `request_out.valid` is produced.
  - Simultaneous write and pop are both serviced.
  - Reset mid-operation drops in-flight packets; `rr_ptr` returns to 0.

## Timing
- Grant at cycle t → FIFO write at t+1 → empty=0 visible after the FWFT latency of the FIFO wrapper.
- `rd_en` at cycle p → `request_out.valid`=1 at p+1.
- prog_full asserted at t → `prog_full_reg`=1 at t+1 → no grant from t+1 onward until it deasserts.
- `fifo_request_signals_out` lags the internal FIFO state by 1 cycle.
- With continuous input and no stall, throughput is 1 request per cycle.

## Test plan
- **Reset.** Hold `ap_rst_n`=0 with all inputs valid → `arbiter_grant_out`=0, `request_out.valid`=0, `fifo_setup_signal`=1. After release, `fifo_setup_signal` falls once the FIFO is ready, with no spurious grant.
- **Round-robin fairness.** N=4, all four inputs continuously valid, downstream always popping → grant sequence 0,1,2,3,0,1,… Each `request_out` has `id_bundle` equal to 0001, 0010, 0100, 1000 in order.
- **Sparse input.** Only inputs 1 and 3 valid with `rr_ptr`=2 → grant 3, then 1, then 3. `rr_ptr` is unchanged on idle cycles.
- **Backpressure.** Downstream `rd_en`=0, all inputs valid, depth 32, `PROG_THRESH`=19 → grants stop once prog_full is registered; full never asserts. Restart `rd_en` → all accepted packets emerge in grant order with none lost or duplicated.
- **`ID_LEVEL`=5.** Packet with `packet_source`=0x5A → output packet is identical bit-for-bit.
- **Mid-stream reset.** Pulse `ap_rst_n` low for 1 cycle during traffic → all outputs return to reset values asynchronously, FIFO empty=1, and the first grant after recovery goes to requestor 0.
